// File: rtl/vj_pyramid_pkg.sv
// Shared definitions for the image-pyramid scheduler.
//   - LAPTOP_WIDTH / LAPTOP_HEIGHT : frame geometry, kept in step with the
//     classifier weights header (vj_weights.vh).
//   - NUM_LEVELS_DEFAULT            : pyramid depth for a 128x96 frame.
//   - IDX_W / WIDTH_W / HEIGHT_W    : widths of level_idx/level_width/level_height.
//   - LEVEL_WIDTH / LEVEL_HEIGHT    : valid image size of each level. Each entry
//     is the largest n with (n-1)+floor((n-1)/4) <= previous-1, i.e. the size
//     the fixed 4/5 downscaler can fill from the previous level.
//   - state_t                       : scheduler FSM states.
package vj_pyramid_pkg;

    localparam int LAPTOP_WIDTH       = 128;
    localparam int LAPTOP_HEIGHT      = 96;
    localparam int NUM_LEVELS_DEFAULT = 7;

    localparam int IDX_W    = 3;
    localparam int WIDTH_W  = 8;
    localparam int HEIGHT_W = 7;

    localparam logic [WIDTH_W-1:0] LEVEL_WIDTH [NUM_LEVELS_DEFAULT] =
        '{8'd128, 8'd103, 8'd83, 8'd67, 8'd54, 8'd44, 8'd36};

    localparam logic [HEIGHT_W-1:0] LEVEL_HEIGHT [NUM_LEVELS_DEFAULT] =
        '{7'd96, 7'd77, 7'd62, 7'd50, 7'd40, 7'd32, 7'd26};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SCALE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/pyramid_scheduler_downscaler.sv
// Fixed 4/5 nearest-neighbour downscaler (purely combinational).
//   img    : input image, LAPTOP_HEIGHT x LAPTOP_WIDTH x 8 bits.
//   scaled : output image; scaled[r][c] = img[r + r/4][c + c/4].
// Every fifth source row/column is dropped. Output positions whose source
// falls outside the frame are driven to zero; they lie outside the valid
// region of the next level and are never read by the detector.
module pyramid_scheduler_downscaler
    import vj_pyramid_pkg::*;
(
    input  logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] img,
    output logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] scaled
);

    for (genvar r = 0; r < LAPTOP_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < LAPTOP_WIDTH; c++) begin : g_col
            localparam int SRC_R = r + r / 4;
            localparam int SRC_C = c + c / 4;
            if (SRC_R < LAPTOP_HEIGHT && SRC_C < LAPTOP_WIDTH) begin : g_map
                assign scaled[r][c] = img[SRC_R][SRC_C];
            end else begin : g_pad
                assign scaled[r][c] = 8'd0;
            end
        end
    end

    // The dropped rows/columns are intentionally not sampled.
    logic unused_pixels;
    assign unused_pixels = ^img;

endmodule

// File: rtl/pyramid_scheduler.sv
// Image-pyramid scheduler for the face detector.
// Captures one frame, presents it as level 0, then repeatedly downscales it
// by 4/5 to produce levels 1..NUM_LEVELS-1, holding each level until the
// detector reports it finished.
//
// Ports:
//   clock, reset          : clock; asynchronous active-high reset.
//   frame_in/frame_valid/frame_ready : source frame handshake.
//   level_img             : current level image (registered, = img_q).
//   level_idx/width/height: current level number and valid region size.
//   level_valid           : level_img/idx/width/height stable and valid.
//   level_done            : detector pulse, current level fully scanned.
//   frame_done            : one-cycle pulse after the last level completes.
//   busy                  : high in every state except IDLE.
//
// Handshakes: a frame transfers on the rising edge where frame_valid and
// frame_ready are both high; frame_valid is ignored whenever frame_ready is
// low. level_done is acted on only on an edge where level_valid is high;
// each level_valid period consumes at most one level_done.
//
// The img_q -> downscaler -> img_q path is a multicycle path of SCALE_CYCLES:
// img_q is stable throughout SCALE and only captured when scale_cnt hits 0.
module pyramid_scheduler
    import vj_pyramid_pkg::*;
#(
    parameter int NUM_LEVELS   = NUM_LEVELS_DEFAULT,  // at most 7
    parameter int SCALE_CYCLES = 2                    // 1..15
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] frame_in,
    input  logic                                            frame_valid,
    output logic                                            frame_ready,
    output logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0] level_img,
    output logic [IDX_W-1:0]                                level_idx,
    output logic [WIDTH_W-1:0]                              level_width,
    output logic [HEIGHT_W-1:0]                             level_height,
    output logic                                            level_valid,
    input  logic                                            level_done,
    output logic                                            frame_done,
    output logic                                            busy
);

    localparam logic [3:0]       SCALE_LOAD = 4'(SCALE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_LEVEL = IDX_W'(NUM_LEVELS - 1);

    state_t                                            state;
    logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0]   img_q;
    logic [LAPTOP_HEIGHT-1:0][LAPTOP_WIDTH-1:0][7:0]   scaled;
    logic [IDX_W-1:0]                                  level;
    logic [3:0]                                        scale_cnt;

    pyramid_scheduler_downscaler u_downscaler (
        .img    (img_q),
        .scaled (scaled)
    );

    // Single FSM; the handshake/status outputs are registered next to the
    // state so they always agree with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            img_q       <= '0;
            level       <= '0;
            scale_cnt   <= '0;
            frame_ready <= 1'b1;
            level_valid <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A stray level_done here is simply not looked at.
                    if (frame_valid) begin
                        img_q       <= frame_in;
                        level       <= '0;
                        state       <= PRESENT;
                        frame_ready <= 1'b0;
                        level_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (level_done) begin
                        level_valid <= 1'b0;
                        if (level == LAST_LEVEL) begin
                            state      <= FINISH;
                            frame_done <= 1'b1;
                        end else begin
                            scale_cnt <= SCALE_LOAD;
                            state     <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    if (scale_cnt == 4'd0) begin
                        img_q       <= scaled;
                        level       <= level + 1'b1;
                        state       <= PRESENT;
                        level_valid <= 1'b1;
                    end else begin
                        scale_cnt <= scale_cnt - 4'd1;
                    end
                end
                FINISH: begin
                    // level is left at the last value; the next capture clears it.
                    frame_done  <= 1'b0;
                    busy        <= 1'b0;
                    frame_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign level_img    = img_q;
    assign level_idx    = level;
    assign level_width  = LEVEL_WIDTH[level];
    assign level_height = LEVEL_HEIGHT[level];

endmodule

// File: doc/pyramid_scheduler.md
# pyramid_scheduler

Sequences the image-pyramid pass for face detection. Captures one 128x96 grayscale frame, presents it to the detector as level 0, then repeatedly applies the existing fixed 4/5 downscaler to produce levels 1..NUM_LEVELS-1. Each level is held stable until the detector reports it is finished. Sits between the frame source (camera/laptop link) and the sliding-window detector.

## Interface

Parameters:
- NUM_LEVELS, 7 — pyramid levels per frame; level 6 is 36x26, the last level at least one 24x24 window tall.
- SCALE_CYCLES, 2 — cycles allowed for the combinational downscaler before its output is captured (multicycle path); legal range 1..15.

Ports:
- clock  in  1  — sole clock.
- reset  in  1  — asynchronous, active-high.
- frame_in  in  [LAPTOP_HEIGHT][LAPTOP_WIDTH][8]  — source frame.
- frame_valid  in  1  — source offers frame_in.
- frame_ready  out  1  — scheduler can accept a frame.
- level_img  out  [LAPTOP_HEIGHT][LAPTOP_WIDTH][8]  — current level image, registered.
- level_idx  out  3  — current level, 0..NUM_LEVELS-1.
- level_width  out  8  — valid columns of level_img.
- level_height  out  7  — valid rows of level_img.
- level_valid  out  1  — level_img/idx/width/height stable and valid.
- level_done  in  1  — one-cycle pulse from detector: current level fully scanned.
- frame_done  out  1  — one-cycle pulse after last level completes.
- busy  out  1  — high in every state except IDLE.

## Operation

- FSM states: IDLE, PRESENT, SCALE, FINISH.
- IDLE: frame_ready=1. When frame_valid=1, the block captures img_q<=frame_in, level<=0, and moves to PRESENT.
- PRESENT: level_valid=1. When level_done=1:
  - If level==NUM_LEVELS-1, go to FINISH.
  - Otherwise load scale_cnt<=SCALE_CYCLES-1 and go to SCALE.
- SCALE: level_valid=0. scale_cnt decrements each cycle. When scale_cnt==0:
  - img_q<=downscaler output (computed from img_q).
  - level<=level+1.
  - Go to PRESENT.
- FINISH: frame_done=1 for exactly one cycle, then go to IDLE.
- level_img is img_q. Outside the valid width/height region its pixel contents are don't-care; the detector must not read them.
- level_width and level_height come from constant tables indexed by level:
  - width: 128, 103, 83, 67, 54, 44, 36.
  - height: 96, 77, 62, 50, 40, 32, 26.
  - Rule: the next dimension is the largest n with (n-1)+floor((n-1)/4) ≤ current-1.
- Boundary rules:
  - level_done outside PRESENT is ignored.
  - frame_valid outside IDLE is ignored; the frame is not captured and frame_ready=0.
  - In IDLE, frame_valid and a stray level_done arriving together: capture the frame, ignore the pulse.
  - level_done held high for several cycles advances exactly one level. A second advance requires the block to re-enter PRESENT and see level_done high again, so a held-high level_done advances once per PRESENT entry.
  - level never wraps; FINISH always resets it to 0 on the next capture.
- Reset (at any time, including mid-frame): state=IDLE, img_q=0, level=0, scale_cnt=0. Resulting outputs:
  - level_valid=0, frame_done=0, busy=0, frame_ready=1.
  - level_idx=0, level_width=128, level_height=96.

## Timing

- Frame accepted on the edge where frame_valid && frame_ready; level_valid=1 on the next cycle.
- level_done at edge t: level_valid drops at t+1, and the next level is valid at t+1+SCALE_CYCLES.
- Last level_done at edge t: frame_done is high during the cycle after t, and frame_ready=1 one cycle after that.
- All outputs are registered or pure decodes of state/level; no input-to-output combinational path.
- The downscaler path from img_q to img_q is constrained as a multicycle path of SCALE_CYCLES.

## Structure

- Shared package vj_pyramid_pkg holds:
  - the state enum;
  - NUM_LEVELS_DEFAULT;
  - LEVEL_WIDTH[] and LEVEL_HEIGHT[] constant arrays;
  - widths of level_idx, width and height.
- LAPTOP_WIDTH/LAPTOP_HEIGHT come from vj_weights.vh.
- Sub-module: the existing downscaler is instantiated once, with img_q driving its input. There is no other sub-module; the FSM, scale counter and image register live in pyramid_scheduler.

## Test plan

- Frame with pixel[r][c]=(r+c)%256; detector pulses level_done 5 cycles after each level_valid rise → 7 levels presented. level_width/height match the tables, and level 1 pixel [4][4] equals source [5][5]=10. One frame_done pulse, then IDLE.
- SCALE_CYCLES=3: level_done at cycle t → next level_valid rises at t+4. Change frame_valid/frame_in while busy → img_q is unaffected and frame_ready=0.
- level_done held high for 20 cycles from level 0 → each PRESENT entry advances one level; behaviour matches the "once per PRESENT entry" rule.
- level_done pulse while in IDLE, or in SCALE → no state change.
- reset asserted mid-level 3, asynchronously between edges → outputs go to reset values immediately. A new frame is then accepted and starts at level 0.
- Two back-to-back frames with frame_valid held high → second frame captured on the cycle after frame_done; frame_done pulses exactly twice in total.
